// File: rtl/ga_pkg.sv
// Shared GA definitions: population geometry, move and state encodings,
// score target and the grid limit used by the optional bounds penalty.
package ga_pkg;

    localparam int unsigned NUM_PATHS  = 50;
    localparam int unsigned MOVES      = 75;
    localparam int unsigned PATH_W     = MOVES * 2;
    localparam int unsigned SCORE_W    = 9;
    localparam int unsigned POP_W      = NUM_PATHS * PATH_W;
    localparam int unsigned FIT_W      = NUM_PATHS * SCORE_W;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned MOVE_IDX_W = 7;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned DIST_W     = 10;
    localparam int unsigned SUM_W      = 11;
    localparam int unsigned PEN_W      = 7;
    localparam int unsigned SCORE_MAX  = (1 << SCORE_W) - 1;

    localparam int TARGET_X = 20;
    localparam int TARGET_Y = 20;
    localparam int GRID_LIM = 63;

    localparam logic [1:0] MV_N = 2'b00;
    localparam logic [1:0] MV_E = 2'b01;
    localparam logic [1:0] MV_S = 2'b10;
    localparam logic [1:0] MV_W = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_SCORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/path_walker.sv
// Walks one path on a signed grid, one 2-bit move per enabled cycle, and
// presents the saturated Manhattan distance to the target combinationally.
// Optional macro BOUNDS_PENALTY_EN: counts out-of-bounds steps and adds them
// to the distance.
// Ports: clk, rst_n (async active-low), clr (return to origin), en (apply mv),
//        mv (move code), dist_c (score of the current position).
module path_walker
    import ga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [1:0]         mv,
    output logic [SCORE_W-1:0] dist_c
);

    logic signed [POS_W-1:0]  x_q, y_q, x_d, y_d;
    logic signed [DIST_W-1:0] dx_c, dy_c;
    logic        [DIST_W-1:0] adx_c, ady_c;
    logic        [SUM_W-1:0]  sum_c;

    // Post-move position
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (mv)
            MV_N:    y_d = y_q + 8'sd1;
            MV_E:    x_d = x_q + 8'sd1;
            MV_S:    y_d = y_q - 8'sd1;
            default: x_d = x_q - 8'sd1;
        endcase
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Manhattan distance; sign-extend before subtracting so -75-20 fits
    always_comb begin
        dx_c  = {{(DIST_W-POS_W){x_q[POS_W-1]}}, x_q} - DIST_W'(TARGET_X);
        dy_c  = {{(DIST_W-POS_W){y_q[POS_W-1]}}, y_q} - DIST_W'(TARGET_Y);
        adx_c = dx_c[DIST_W-1] ? DIST_W'(-dx_c) : DIST_W'(dx_c);
        ady_c = dy_c[DIST_W-1] ? DIST_W'(-dy_c) : DIST_W'(dy_c);
        sum_c = {1'b0, adx_c} + {1'b0, ady_c};
    end

`ifdef BOUNDS_PENALTY_EN
    localparam logic signed [POS_W-1:0] LIM = POS_W'(GRID_LIM);

    logic [PEN_W-1:0] pen_q;
    logic             out_c;
    logic [SUM_W-1:0] tot_c;

    assign out_c = (x_d > LIM) || (x_d < -LIM) || (y_d > LIM) || (y_d < -LIM);

    // Out-of-bounds step counter, judged on the post-move position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pen_q <= '0;
        end else if (clr) begin
            pen_q <= '0;
        end else if (en && out_c) begin
            pen_q <= pen_q + 7'd1;
        end
    end

    assign tot_c  = sum_c + SUM_W'(pen_q);
    assign dist_c = (tot_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : tot_c[SCORE_W-1:0];
`else
    assign dist_c = (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];
`endif

endmodule

// File: rtl/fitness_eval.sv
// Scores each path of the population by walking it and measuring distance to
// the target, keeping a per-path score vector and the best (lowest) path.
// Optional macro BOUNDS_PENALTY_EN (see path_walker) adds an out-of-bounds
// penalty; timing is identical either way.
// Ports: clk, rst_n (async active-low), start (sampled in IDLE), pop
//        (population, snapshotted on start), fitness (score vector),
//        best_idx / best_score, busy (run in progress), done (1-cycle pulse).
module fitness_eval
    import ga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [POP_W-1:0]   pop,
    output logic [FIT_W-1:0]   fitness,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic               busy,
    output logic               done
);

    logic [1:0]            state_q, state_d;
    logic [POP_W-1:0]      pop_q;
    logic [IDX_W-1:0]      path_idx_q;
    logic [MOVE_IDX_W-1:0] move_idx_q;

    logic                  start_acc_c;
    logic                  last_move_c;
    logic                  last_path_c;
    logic [12:0]           path_base_c;
    logic [PATH_W-1:0]     path_c;
    logic [7:0]            mv_base_c;
    logic [1:0]            mv_c;
    logic [8:0]            fit_base_c;
    logic [SCORE_W-1:0]    score_c;

    // Start is ignored in the cycle done is high, so back-to-back runs are
    // separated by at least one idle cycle.
    assign start_acc_c = (state_q == ST_IDLE) && start && !done;
    assign last_move_c = (move_idx_q == MOVE_IDX_W'(MOVES - 1));
    assign last_path_c = (path_idx_q == IDX_W'(NUM_PATHS - 1));

    // Current move selection from the snapshot
    always_comb begin
        path_base_c = 13'(path_idx_q) * 13'(PATH_W);
        path_c      = pop_q[path_base_c +: PATH_W];
        mv_base_c   = {move_idx_q, 1'b0};
        mv_c        = path_c[mv_base_c +: 2];
        fit_base_c  = 9'(path_idx_q) * 9'(SCORE_W);
    end

    path_walker u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc_c || (state_q == ST_SCORE)),
        .en     (state_q == ST_WALK),
        .mv     (mv_c),
        .dist_c (score_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc_c) state_d = ST_WALK;
            ST_WALK:  if (last_move_c) state_d = ST_SCORE;
            ST_SCORE: state_d = last_path_c ? ST_DONE : ST_WALK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: snapshot, indices, score vector, best tracking, handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q      <= '0;
            path_idx_q <= '0;
            move_idx_q <= '0;
            fitness    <= '0;
            best_idx   <= '0;
            best_score <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_c) begin
                        pop_q      <= pop;
                        path_idx_q <= '0;
                        move_idx_q <= '0;
                        fitness    <= '0;
                        best_idx   <= '0;
                        best_score <= '0;
                        busy       <= 1'b1;
                    end
                end
                ST_WALK: begin
                    move_idx_q <= move_idx_q + 7'd1;
                end
                ST_SCORE: begin
                    fitness[fit_base_c +: SCORE_W] <= score_c;
                    // Strict compare keeps the lower index on ties
                    if ((path_idx_q == '0) || (score_c < best_score)) begin
                        best_idx   <= path_idx_q;
                        best_score <= score_c;
                    end
                    move_idx_q <= '0;
                    if (!last_path_c) begin
                        path_idx_q <= path_idx_q + 6'd1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fitness_eval.sv
module tb_fitness_eval;
    import ga_pkg::*;

    localparam int LAT = 3801;
`ifdef BOUNDS_PENALTY_EN
    localparam int ALLN = 87;
`else
    localparam int ALLN = 75;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [POP_W-1:0]   pop = '0;
    logic [FIT_W-1:0]   fitness;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best_score;
    logic               busy;
    logic               done;

    fitness_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pop        (pop),
        .fitness    (fitness),
        .best_idx   (best_idx),
        .best_score (best_score),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [FIT_W-1:0]   fit;
        logic [IDX_W-1:0]   bi;
        logic [SCORE_W-1:0] bs;
        int                 acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [FIT_W-1:0] act, input logic [FIT_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // 20 E, 21 N, then 34 alternating E/W: ends at (20,21), score 1
    function automatic logic [PATH_W-1:0] near_path();
        logic [PATH_W-1:0] p;
        p = '0;
        for (int j = 0; j < MOVES; j++) begin
            if (j < 20)                 p[j*2 +: 2] = MV_E;
            else if (j < 41)            p[j*2 +: 2] = MV_N;
            else if (((j - 41) % 2) == 0) p[j*2 +: 2] = MV_E;
            else                        p[j*2 +: 2] = MV_W;
        end
        return p;
    endfunction

    // Population: all N except paths a and b (negative = unused) set near
    function automatic logic [POP_W-1:0] mk_pop(input int a, input int b);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < int'(NUM_PATHS); i++)
            if (i == a || i == b) p[i*PATH_W +: PATH_W] = near_path();
        return p;
    endfunction

    function automatic logic [FIT_W-1:0] mk_fit(input int a, input int b);
        logic [FIT_W-1:0] f;
        f = '0;
        for (int i = 0; i < int'(NUM_PATHS); i++)
            f[i*SCORE_W +: SCORE_W] = (i == a || i == b) ? 9'd1 : SCORE_W'(ALLN);
        return f;
    endfunction

    // Monitor: every done pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk_int("done_single_pulse", 32'(prev_done), 0);
            chk_int("busy_low_at_done", 32'(busy), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                mon_e = exp_q.pop_front();
                chk_vec("fitness", fitness, mon_e.fit);
                chk_int("best_idx", 32'(best_idx), 32'(mon_e.bi));
                chk_int("best_score", 32'(best_score), 32'(mon_e.bs));
                chk_int("latency", cyc - mon_e.acc, LAT);
            end
        end
        prev_done = done;
    end

    task automatic launch(input logic [POP_W-1:0] p, input bit push,
                          input logic [FIT_W-1:0] f, input int bi, input int bs);
        exp_t e;
        @(negedge clk);
        pop   = p;
        start = 1'b1;
        e.fit = f;
        e.bi  = IDX_W'(bi);
        e.bs  = SCORE_W'(bs);
        e.acc = cyc + 1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk_int("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_runs();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 5000 cycles");
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_int("reset_busy", 32'(busy), 0);
        chk_int("reset_done", 32'(done), 0);
        chk_vec("reset_fitness", fitness, '0);
        chk_int("reset_best_score", 32'(best_score), 0);
        rst_n = 1'b1;

        // All N: every path ends at (0,75)
        launch(mk_pop(-1, -1), 1'b1, mk_fit(-1, -1), 0, ALLN);
        wait_runs();

        // Single near path at index 7
        launch(mk_pop(7, -1), 1'b1, mk_fit(7, -1), 7, 1);
        wait_runs();
        repeat (5) @(negedge clk);
        chk_int("best_score_held", 32'(best_score), 1);

        // Tie between 3 and 9 keeps index 3
        launch(mk_pop(3, 9), 1'b1, mk_fit(3, 9), 3, 1);
        wait_runs();

        // Restart attempt and pop change mid-run are both ignored
        launch(mk_pop(3, 9), 1'b1, mk_fit(3, 9), 3, 1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        pop   = mk_pop(-1, -1);
        @(negedge clk);
        start = 1'b0;
        wait_runs();

        // Asynchronous reset mid-run clears everything immediately
        launch(mk_pop(-1, -1), 1'b0, '0, 0, 0);
        repeat (2000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_int("midrst_busy", 32'(busy), 0);
        chk_int("midrst_done", 32'(done), 0);
        chk_vec("midrst_fitness", fitness, '0);
        chk_int("midrst_best_idx", 32'(best_idx), 0);
        chk_int("midrst_best_score", 32'(best_score), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fresh run after reset completes normally
        launch(mk_pop(7, -1), 1'b1, mk_fit(7, -1), 7, 1);
        wait_runs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fitness_eval.md
Name: fitness_eval

Overview:
Scores every path of the current 50-path population before the selection stage runs each generation. Each 150-bit path is 75 moves of 2 bits, walked on a signed grid from origin (0,0). Score is the Manhattan distance from the final position to a fixed target; lower is better. Produces a per-path score vector plus the best index/score, with the same start/done handshake as the other GA stages.

Parameters:
NUM_PATHS, 50, paths in population
MOVES, 75, moves per path
PATH_W, 150, bits per path (MOVES*2)
SCORE_W, 9, score width, unsigned
TARGET_X, 20, target x, signed
TARGET_Y, 20, target y, signed
GRID_LIM, 63, bounds limit used only with the optional feature

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin evaluation; sampled only in IDLE
pop  input  7500  population; path i = pop[i*150 +: 150], move j = path[j*2 +: 2]
fitness  output  450  score of path i at fitness[i*9 +: 9]
best_idx  output  6  index of lowest-scoring path
best_score  output  9  score of best_idx
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when all scores are valid

Behaviour:
- Move encoding: 00 N (y+1), 01 E (x+1), 10 S (y-1), 11 W (x-1). x and y are 8-bit signed; the range ±75 never overflows.
- States and transitions:
  - IDLE: start=1 snapshots pop into an internal register, clears path_idx and move_idx, sets x=y=0, and moves to WALK.
  - WALK: applies one move per cycle. After move 74, goes to SCORE.
  - SCORE: one cycle.
    - Computes |x-TARGET_X|+|y-TARGET_Y| into 9 bits, saturating at 511, and writes it to fitness[path_idx].
    - Updates best if score < best_score (strict). On ties the lower index is kept. Path 0 always initialises best.
    - If path_idx < 49: increments path_idx, clears x, y and move_idx, and returns to WALK. Otherwise goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is asserted exactly 50*76+1 = 3801 cycles after the edge that accepted start.
- busy: asserts the cycle after start is accepted and deasserts with the done pulse.
- Output timing:
  - fitness, best_idx and best_score are valid and held from done until the next accepted start.
  - Accepting start clears them to 0.
  - During a run they update as paths complete. Consumers read them only after done.
- start while busy is ignored. Changes to pop during a run are ignored because of the snapshot.
- start asserted in the DONE cycle is ignored. It is accepted on the following IDLE cycle if still high.
- Reset (asynchronous, any time including mid-run): state returns to IDLE; all outputs, counters, x, y and the snapshot go to 0; no done pulse.

Optional Feature:
BOUNDS_PENALTY_EN
- Defined: a 7-bit per-path counter increments on each WALK cycle whose post-move position has |x|>GRID_LIM or |y|>GRID_LIM. SCORE adds this counter to the distance, saturating at 511. The counter clears per path.
- Undefined: no counter is present and the score is pure distance. Latency is identical in both builds.

Decomposition:
- Shared package ga_pkg:
  - NUM_PATHS, MOVES, PATH_W, SCORE_W and POP_W (7500).
  - The move encodings as named constants MV_N, MV_E, MV_S, MV_W.
  - The state encoding.
  The other GA stages use the same package.
- One sub-module, path_walker:
  - Holds x and y and applies one 2-bit move per enable; clear input.
  - Combinational distance output (including the penalty counter under the macro).
- fitness_eval keeps the FSM, indices, snapshot, score vector and best tracking.

Test Plan:
- Population all zeros (all N; each path ends at (0,75)) -> every fitness = 75, best_idx=0, best_score=75, done exactly 3801 cycles after start.
- Path 7 = 20 E, 21 N, then 34 alternating E/W; others all N -> fitness[7]=1, best_idx=7, best_score=1, other paths 75.
- Paths 3 and 9 both set to the path-7 pattern above; others all N -> best_idx=3, best_score=1 (tie keeps lower index).
- Second start pulse 100 cycles into a run, plus pop changed mid-run -> single done pulse at 3801, scores match the original snapshot.
- rst_n low at cycle 2000 -> busy=0, done=0, fitness/best cleared immediately. A new start then completes normally in 3801 cycles.
- BOUNDS_PENALTY_EN defined, all-N population, GRID_LIM=63 -> every fitness = 75+12 = 87. With the macro undefined -> 75.
